// File: rtl/core_ex_div_pkg.sv
// rtl/core_ex_div_pkg.sv - shared funct3 codes, FSM states and step counts for the EX divider
package core_ex_div_pkg;

  localparam int OPERAND_WIDTH = 64;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [6:0] DIV_STEPS_64 = 7'd64;
  localparam logic [6:0] DIV_STEPS_32 = 7'd32;

endpackage

// File: rtl/core_ex_div_if.sv
// rtl/core_ex_div_if.sv - pipeline-side bundle between ID/EX and the EX divider
interface core_ex_div_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      funct3;
  logic            word;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, word, rs1_data, rs2_data, flush,
    input  stall, valid, result
  );

  modport slave (
    input  start, funct3, word, rs1_data, rs2_data, flush,
    output stall, valid, result
  );
endinterface

// File: rtl/core_div_step.sv
// rtl/core_div_step.sv - one combinational radix-2 restoring division step
module core_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // rem < divisor always holds, so the shifted remainder fits in W+1 bits
  assign shifted = {rem, quo[W-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/core_ex_div.sv
// rtl/core_ex_div.sv - multi-cycle RV64M divider in EX; W variants built only with CORE_DIV_W_EN
module core_ex_div
  import core_ex_div_pkg::*;
#(
  parameter int XLEN = OPERAND_WIDTH
) (
  input logic          clk,
  input logic          rst,
  core_ex_div_if.slave bus
);

  div_state_t      state;
  logic [6:0]      count;
  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic            neg_q, neg_r, is_rem_q;
  logic            valid_q;
  logic [XLEN-1:0] result_q;

  logic            signed_op, is_rem, a_sign, b_sign, div_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg, quo_init;
  logic [XLEN-1:0] special_res, rem_next, quo_next, q_fix, r_fix, res_pre, res_fmt;
  logic [6:0]      steps;

  assign signed_op = (bus.funct3 == FUNCT3_DIV) || (bus.funct3 == FUNCT3_REM);
  assign is_rem    = (bus.funct3 == FUNCT3_REM) || (bus.funct3 == FUNCT3_REMU);

`ifdef CORE_DIV_W_EN
  logic word_q;

  always_comb begin
    a_ext    = bus.rs1_data;
    b_ext    = bus.rs2_data;
    min_neg  = {1'b1, {(XLEN-1){1'b0}}};
    steps    = DIV_STEPS_64;
    if (bus.word) begin
      a_ext   = {{(XLEN-32){signed_op & bus.rs1_data[31]}}, bus.rs1_data[31:0]};
      b_ext   = {{(XLEN-32){signed_op & bus.rs2_data[31]}}, bus.rs2_data[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, {31{1'b0}}};
      steps   = DIV_STEPS_32;
    end
  end

  // Left-aligning the 32-bit magnitude lets 32 steps produce the full quotient
  assign quo_init = bus.word ? {a_abs[XLEN-33:0], 32'b0} : a_abs;

  always_comb begin
    res_fmt = res_pre;
    if ((state == DIV_IDLE) ? bus.word : word_q)
      res_fmt = {{(XLEN-32){res_pre[31]}}, res_pre[31:0]};
  end
`else
  logic unused_word;
  assign unused_word = bus.word;
  assign a_ext       = bus.rs1_data;
  assign b_ext       = bus.rs2_data;
  assign min_neg     = {1'b1, {(XLEN-1){1'b0}}};
  assign steps       = DIV_STEPS_64;
  assign quo_init    = a_abs;
  assign res_fmt     = res_pre;
`endif

  assign a_sign   = signed_op & a_ext[XLEN-1];
  assign b_sign   = signed_op & b_ext[XLEN-1];
  assign a_abs    = a_sign ? -a_ext : a_ext;
  assign b_abs    = b_sign ? -b_ext : b_ext;
  assign div_zero = (b_ext == '0);
  assign ovf      = signed_op && (a_ext == min_neg) && (&b_ext);

  always_comb begin
    if (div_zero) special_res = is_rem ? a_ext : '1;
    else          special_res = is_rem ? '0 : a_ext;
  end

  core_div_step #(.W(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fix   = neg_q ? -quo_next : quo_next;
  assign r_fix   = neg_r ? -rem_next : rem_next;
  assign res_pre = (state == DIV_IDLE) ? special_res : (is_rem_q ? r_fix : q_fix);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      count    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_rem_q <= 1'b0;
`ifdef CORE_DIV_W_EN
      word_q   <= 1'b0;
`endif
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.flush) begin
        state <= DIV_IDLE;
      end else begin
        case (state)
          DIV_IDLE: if (bus.start) begin
            neg_q    <= signed_op & (a_sign ^ b_sign);
            neg_r    <= a_sign;
            is_rem_q <= is_rem;
`ifdef CORE_DIV_W_EN
            word_q   <= bus.word;
`endif
            div_q    <= b_abs;
            rem_q    <= '0;
            quo_q    <= quo_init;
            if (div_zero || ovf) begin
              result_q <= res_fmt;
              valid_q  <= 1'b1;
              state    <= DIV_DONE;
            end else begin
              count <= steps;
              state <= DIV_CALC;
            end
          end
          DIV_CALC: begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count - 7'd1;
            if (count == 7'd1) begin
              result_q <= res_fmt;
              valid_q  <= 1'b1;
              state    <= DIV_DONE;
            end
          end
          default: state <= DIV_IDLE;
        endcase
      end
    end
  end

  assign bus.stall  = ((state == DIV_IDLE) && bus.start && !bus.flush) || (state == DIV_CALC);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule
